// File: rtl/nibble_serial_adder.sv
// Serial W-bit adder: one shared 4-bit ripple slice processes a nibble per clock.
// Optional signed-overflow output is built when NSA_OVERFLOW_EN is defined.

module nsa_rpa (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c
);
    logic w_c;

    always_comb begin
        o_s = '0;
        w_c = i_c;
        for (int k = 0; k < 4; k++) begin
            o_s[k] = i_a[k] ^ i_b[k] ^ w_c;
            w_c    = (i_a[k] & i_b[k]) | (w_c & (i_a[k] ^ i_b[k]));
        end
        o_c = w_c;
    end
endmodule

module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [4*NIBBLES-1:0] i_a,
    input  logic [4*NIBBLES-1:0] i_b,
    input  logic                 i_cin,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [4*NIBBLES-1:0] o_sum,
`ifdef NSA_OVERFLOW_EN
    output logic                 o_ovf,
`endif
    output logic                 o_cout
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        r_state, w_state_d;
    logic [W-1:0]  r_a, r_b, r_sum;
    logic [CW-1:0] r_cnt;
    logic          r_carry, r_cout;
    logic [3:0]    w_rpa_s;
    logic          w_rpa_co;
    logic          w_last;
    logic [W+3:0]  w_sum_cat;

    nsa_rpa u_rpa (
        .i_a (r_a[3:0]),
        .i_b (r_b[3:0]),
        .i_c (r_carry),
        .o_s (w_rpa_s),
        .o_c (w_rpa_co)
    );

    assign w_last = (r_cnt == LAST);
    // New nibble enters at the top; concatenate-and-shift also covers NIBBLES=1.
    assign w_sum_cat = {w_rpa_s, r_sum} >> 4;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_d;
    end

    always_comb begin
        w_state_d   = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_in_ready = 1'b1;
                if (i_in_valid) w_state_d = StRun;
            end
            StRun: begin
                if (w_last) w_state_d = StDone;
            end
            StDone: begin
                o_out_valid = 1'b1;
                if (i_out_ready) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

`ifdef NSA_OVERFLOW_EN
    logic r_ovf;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
`ifdef NSA_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            if (r_state == StIdle && i_in_valid) begin
                r_a     <= i_a;
                r_b     <= i_b;
                r_carry <= i_cin;
                r_cnt   <= '0;
            end else if (r_state == StRun) begin
                r_a     <= r_a >> 4;
                r_b     <= r_b >> 4;
                r_sum   <= w_sum_cat[W-1:0];
                r_carry <= w_rpa_co;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_cout <= w_rpa_co;
`ifdef NSA_OVERFLOW_EN
                    r_ovf  <= (r_a[3] == r_b[3]) && (w_rpa_s[3] != r_a[3]);
`endif
                end
            end
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;
`ifdef NSA_OVERFLOW_EN
    assign o_ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder (NIBBLES=4); covers ovf when
// NSA_OVERFLOW_EN is defined.

module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [15:0] a, b, sum;
`ifdef NSA_OVERFLOW_EN
    logic        ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .i_cin       (cin),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_sum       (sum),
`ifdef NSA_OVERFLOW_EN
        .o_ovf       (ovf),
`endif
        .o_cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand set, wait for out_valid, return latency and result.
    task automatic start_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                            output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic vc, input logic [15:0] esum, input logic ecout);
        int lat;
        start_op(va, vb, vc, lat);
        check({tag, "_lat"}, lat, 4);
        check({tag, "_sum"}, sum, esum);
        check({tag, "_cout"}, cout, ecout);
        finish_op();
    endtask

    logic [15:0] held_sum;
    logic        held_cout;
    int          lat;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);

        run_vec("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        run_vec("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_vec("cin_ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        run_vec("msb_carry", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        run_vec("mixed", 16'h9999, 16'h1111, 1'b1, 16'hAAAB, 1'b0);
        run_vec("alt", 16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1);

        // Backpressure: result and handshake state frozen while out_ready is low.
        start_op(16'h0F0F, 16'h1111, 1'b0, lat);
        check("bp_lat", lat, 4);
        held_sum = sum;
        held_cout = cout;
        check("bp_sum", held_sum, 16'h2020);
        check("bp_cout", held_cout, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_sum", sum, 16'h2020);
            check("bp_hold_cout", cout, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        finish_op();
        check("bp_valid_drop", out_valid, 0);
        check("bp_ready_rise", in_ready, 1);

        // Operands wiggle during RUN with in_valid held: only the accepted set counts.
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        tick();
        lat = 0;
        while (!out_valid && lat < 50) begin
            check("hold_no_accept", in_ready, 0);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            tick();
            lat++;
        end
        check("hold_lat", lat, 4);
        check("hold_in_ready_done", in_ready, 0);
        check("hold_sum", sum, 16'h5555);
        check("hold_cout", cout, 0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("hold_idle", in_ready, 1);

        // Reset in the second RUN cycle aborts the operation.
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        tick(); tick();
        check("abort_no_result", out_valid, 0);
        run_vec("after_abort", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

`ifdef NSA_OVERFLOW_EN
        start_op(16'h7FFF, 16'h0001, 1'b0, lat);
        check("ovf1_sum", sum, 16'h8000);
        check("ovf1_ovf", ovf, 1);
        check("ovf1_cout", cout, 0);
        finish_op();
        start_op(16'h8000, 16'hFFFF, 1'b0, lat);
        check("ovf2_sum", sum, 16'h7FFF);
        check("ovf2_ovf", ovf, 1);
        check("ovf2_cout", cout, 1);
        finish_op();
        start_op(16'h0001, 16'hFFFF, 1'b0, lat);
        check("ovf3_sum", sum, 16'h0000);
        check("ovf3_ovf", ovf, 0);
        check("ovf3_cout", cout, 1);
        finish_op();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-word adder front-end that adds two N-nibble operands one nibble per clock, driving a single 4-bit ripple-carry adder slice (rpa) and collecting its sum and carry-out. It trades latency for area: one 4-bit slice serves operands of any width. Operands arrive over a valid/ready handshake, and the result leaves over another valid/ready handshake. It sits between the operand source and the result consumer in the datapath.

Parameters:
NIBBLES, 4, operand width in nibbles (operand width W = 4*NIBBLES); legal range 1..16

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand set a/b/cin is valid
in_ready  output  1  block can accept operands (IDLE only)
a  input  W  operand A, unsigned / two's complement
b  input  W  operand B
cin  input  1  carry into nibble 0
out_valid  output  1  sum/cout valid, held until accepted
out_ready  input  1  consumer accepts result
sum  output  W  a+b+cin, low W bits
cout  output  1  carry out of top nibble

Behaviour:
- Structure:
  - One rpa instance, fed with the low nibble of the A and B shift registers and the carry register.
  - Its s[3:0] shifts into the top of the sum register; its c_out updates the carry register.
- FSM states: IDLE, RUN, DONE.
- Reset (rst=1 at a clock edge):
  - state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; nibble counter=0; carry register=0.
  - Reset mid-RUN or mid-DONE aborts the operation. No result is emitted, and the pending result is discarded.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready:
    - Load A/B shift registers from a/b and the carry register from cin.
    - Clear the counter and go to RUN.
  - a/b/cin are sampled only at this edge; later changes are ignored.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge: add nibble cnt and shift A/B right by 4. The rpa sum shifts into sum[W-1:W-4] with the existing contents moving right by 4, and the carry register takes rpa c_out.
  - The edge that processes nibble NIBBLES-1 moves to DONE and sets cout to that nibble's c_out.
  - This applies for NIBBLES=1 as well: one RUN cycle.
- DONE:
  - out_valid=1; sum and cout are held stable until handshake.
  - On out_valid&out_ready: go to IDLE and drop out_valid. in_ready rises the following cycle; there is no same-cycle re-accept.
- Latency:
  - out_valid rises NIBBLES clocks after the accept edge.
  - Throughput is one operation per NIBBLES+2 cycles with out_ready held high.
- Arithmetic:
  - {cout,sum} = a + b + cin exactly, i.e. W+1 bits, modulo nothing.
  - Carry propagates between nibbles through the carry register only; there is no combinational path from cin to cout.
- Outputs in IDLE/RUN: sum keeps its last value (or 0 after reset) and is not guaranteed meaningful.
- out_ready while not in DONE is ignored. in_valid outside IDLE is ignored.

Optional Feature:
NSA_OVERFLOW_EN
- Defined:
  - Adds output port ovf (1 bit), the two's-complement signed overflow, equal to (carry into top bit) XOR (carry out of top bit).
  - Computed during the last RUN cycle from the top nibble's operand MSBs and sum MSB: ovf = (a_msb==b_msb) && (s_msb!=a_msb).
  - Registered with cout and held through DONE; reset value 0.
- Undefined: port ovf does not exist and no overflow logic is built.

Test Plan:
- NIBBLES=4, a=16'h1234, b=16'h4321, cin=0 -> out_valid exactly 4 clocks after accept; sum=16'h5555, cout=0.
- a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1 (carry ripples through all 4 nibbles); then a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> sum/cout stable and in_ready=0 throughout; out_ready=1 -> out_valid drops next edge, in_ready=1 the cycle after.
- Change a/b every cycle during RUN and hold in_valid=1 -> result reflects only the values sampled at the accept edge; no second accept before IDLE.
- Assert rst in the 2nd RUN cycle -> next cycle state IDLE, in_ready=1, out_valid=0, sum=0, cout=0; the next operation 16'h0F0F+16'h00F1 gives 16'h1000, cout=0.
- With NSA_OVERFLOW_EN: 16'h7FFF+16'h0001 -> sum=16'h8000, ovf=1, cout=0; 16'h8000+16'hFFFF -> sum=16'h7FFF, ovf=1, cout=1; 16'h0001+16'hFFFF -> ovf=0.
